// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, responder state encoding and error-count limit
package bus_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
   localparam logic [7:0] ERR_MAX = 8'd255;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      WAIT    = 3'd2,
      ACK     = 3'd3,
      RELEASE = 3'd4
   } resp_state_t;

endpackage

// File: rtl/bus_resp_mem.sv
// rtl/bus_resp_mem.sv - responder register file, sync write / async read
module bus_resp_mem
   import bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Read port sees the pre-edge contents, so a same-edge write is not forwarded.
   assign o_rdata = r_mem[i_raddr];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - as/ds handshake target returning register-file words on data/da
module bus_responder
   import bus_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              as,
   input  logic              rw,
   input  logic              ds,
   output logic              da,
   output logic [DATA_W-1:0] data,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   resp_state_t       r_state;
   resp_state_t       w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr_q;
   logic              r_rw_q;
   logic              r_da;
   logic [DATA_W-1:0] r_data;
   logic              r_busy;
   logic [7:0]        r_err_cnt;
   logic              w_abort;
   logic              w_ack_enter;
   logic              w_ack_exit;
   logic              w_err_inc;
   logic [DATA_W-1:0] w_rdata;

   bus_resp_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (load_en),
      .i_waddr (load_addr),
      .i_wdata (load_data),
      .i_raddr (r_addr_q),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_abort     = 1'b0;
      w_ack_enter = 1'b0;
      w_ack_exit  = 1'b0;
      case (r_state)
         IDLE: begin
            if (as) w_state_nxt = ADDR;
         end
         ADDR: begin
            if (ds) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ACK;
                  w_ack_enter = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = WAIT_LOAD;
               end
            end else if (!as) begin
               w_state_nxt = IDLE;
               w_abort     = 1'b1;
            end
         end
         WAIT: begin
            if (!ds || !as) begin
               w_state_nxt = IDLE;
               w_abort     = 1'b1;
            end else if (r_cnt == 4'd0) begin
               w_state_nxt = ACK;
               w_ack_enter = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ACK: begin
            // Only ds ends the data phase; as may already be low here.
            if (!ds) begin
               w_state_nxt = RELEASE;
               w_ack_exit  = 1'b1;
            end
         end
         RELEASE: begin
            if (!as) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_err_inc = w_abort | (w_ack_enter & ~r_rw_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_addr_q  <= '0;
         r_rw_q    <= 1'b0;
         r_da      <= 1'b0;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         if (r_state == IDLE && as) begin
            r_addr_q <= addr;
            r_rw_q   <= rw;
         end
         if (w_ack_enter) begin
            r_da   <= 1'b1;
            r_data <= r_rw_q ? w_rdata : '0;
         end else if (w_ack_exit) begin
            r_da   <= 1'b0;
            r_data <= '0;
         end
         if (w_err_inc && r_err_cnt != ERR_MAX) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign da      = r_da;
   assign data    = r_data;
   assign busy    = r_busy;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - randomized self-checking bench for bus_responder (2 and 0 wait states)
module tb_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addr;
   logic        bus_as;
   logic        rw;
   logic        ds;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic        da2, da0;
   logic [15:0] data2, data0;
   logic        busy2, busy0;
   logic [7:0]  err2, err0;

   logic [15:0] model_mem [256];
   int          model_err2;
   int          model_err0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .addr(addr), .as(bus_as), .rw(rw), .ds(ds),
      .da(da2), .data(data2), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy2), .err_cnt(err2)
   );

   bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .addr(addr), .as(bus_as), .rw(rw), .ds(ds),
      .da(da0), .data(data0), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy0), .err_cnt(err0)
   );

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
      model_mem[a] = d;
   endtask

   // load_mode: 0 none, 1 load addr on the ACK-entry edge, 2 load addr one edge earlier (in WAIT)
   task automatic do_xfer(input logic [7:0] a, input logic r, input int load_mode, input logic [15:0] ld);
      logic [15:0] exp2;
      logic [15:0] exp0;
      exp0 = r ? model_mem[a] : 16'h0000;
      bus_as = 1'b1; addr = a; rw = r;
      tick();
      total_cnt++; if (busy2 !== 1'b1) $display("FAIL xfer_busy_addr: got %b expected 1", busy2); else pass_cnt++;
      ds = 1'b1;
      tick();
      if (!r) model_err0 = sat_inc(model_err0);
      total_cnt++; if (da2 !== 1'b0) $display("FAIL xfer_da_early_k: got %b expected 0", da2); else pass_cnt++;
      total_cnt++; if (da0 !== 1'b1 || data0 !== exp0) $display("FAIL xfer0_ack: got da=%b data=%h expected da=1 data=%h", da0, data0, exp0); else pass_cnt++;
      if (load_mode == 2) begin load_en = 1'b1; load_addr = a; load_data = ld; end
      tick();
      load_en = 1'b0;
      if (load_mode == 2) model_mem[a] = ld;
      total_cnt++; if (da2 !== 1'b0) $display("FAIL xfer_da_early_k1: got %b expected 0", da2); else pass_cnt++;
      exp2 = r ? model_mem[a] : 16'h0000;
      if (load_mode == 1) begin load_en = 1'b1; load_addr = a; load_data = ld; end
      tick();
      load_en = 1'b0;
      if (load_mode == 1) model_mem[a] = ld;
      if (!r) model_err2 = sat_inc(model_err2);
      total_cnt++; if (da2 !== 1'b1 || data2 !== exp2) $display("FAIL xfer_ack: addr=%h got da=%b data=%h expected da=1 data=%h", a, da2, data2, exp2); else pass_cnt++;
      total_cnt++; if (err2 !== 8'(model_err2) || err0 !== 8'(model_err0)) $display("FAIL xfer_err: got %0d/%0d expected %0d/%0d", err2, err0, model_err2, model_err0); else pass_cnt++;
      tick();
      total_cnt++; if (da2 !== 1'b1 || data2 !== exp2) $display("FAIL xfer_hold: got da=%b data=%h expected da=1 data=%h", da2, data2, exp2); else pass_cnt++;
      ds = 1'b0;
      tick();
      total_cnt++; if (da2 !== 1'b0 || data2 !== 16'h0000 || busy2 !== 1'b1) $display("FAIL xfer_release: got da=%b data=%h busy=%b expected 0 0000 1", da2, data2, busy2); else pass_cnt++;
      bus_as = 1'b0;
      tick();
      total_cnt++; if (busy2 !== 1'b0 || busy0 !== 1'b0) $display("FAIL xfer_idle: got busy=%b/%b expected 0/0", busy2, busy0); else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus_as = 1'b0; ds = 1'b0; rw = 1'b1; addr = 8'h00;
      load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
      tick(); tick();
      total_cnt++; if (da2 !== 1'b0 || data2 !== 16'h0 || busy2 !== 1'b0 || err2 !== 8'd0) $display("FAIL reset_state: got da=%b data=%h busy=%b err=%0d expected zeros", da2, data2, busy2, err2); else pass_cnt++;
      rst = 1'b0;
      model_err2 = 0; model_err0 = 0;
      tick();
   endtask

   task automatic test_basic_read();
      load(8'h12, 16'hBEEF);
      load(8'hFF, 16'h0001);
      do_xfer(8'h12, 1'b1, 0, 16'h0);
      do_xfer(8'hFF, 1'b1, 0, 16'h0);
   endtask

   task automatic test_back_to_back();
      load(8'h00, 16'h5A5A);
      bus_as = 1'b1; addr = 8'hFF; rw = 1'b1;
      tick(); ds = 1'b1;
      tick(); tick(); tick();
      total_cnt++; if (data2 !== 16'h0001) $display("FAIL b2b_first: got %h expected 0001", data2); else pass_cnt++;
      ds = 1'b0; addr = 8'h00;
      tick(); ds = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++; if (da2 !== 1'b0 || da0 !== 1'b0 || busy2 !== 1'b1) $display("FAIL b2b_held_as: got da=%b/%b busy=%b expected 0/0 1", da2, da0, busy2); else pass_cnt++;
      end
      ds = 1'b0; bus_as = 1'b0;
      tick();
      do_xfer(8'h00, 1'b1, 0, 16'h0);
   endtask

   task automatic test_abort_wait();
      logic seen_da;
      seen_da = 1'b0;
      bus_as = 1'b1; addr = 8'h05; rw = 1'b1;
      tick(); seen_da |= da2;
      ds = 1'b1;
      tick(); seen_da |= da2;
      ds = 1'b0; bus_as = 1'b0;
      tick(); seen_da |= da2;
      model_err2 = sat_inc(model_err2);
      total_cnt++; if (err2 !== 8'(model_err2) || busy2 !== 1'b0) $display("FAIL abort_wait_err: got err=%0d busy=%b expected %0d 0", err2, busy2, model_err2); else pass_cnt++;
      tick(); seen_da |= da2;
      total_cnt++; if (seen_da !== 1'b0) $display("FAIL abort_wait_da: got %b expected 0", seen_da); else pass_cnt++;
   endtask

   task automatic test_write_request();
      load(8'h40, 16'hC0DE);
      do_xfer(8'h40, 1'b0, 0, 16'h0);
      do_xfer(8'h40, 1'b1, 0, 16'h0);
   endtask

   task automatic test_load_collision();
      load(8'h30, 16'h1111);
      do_xfer(8'h30, 1'b1, 1, 16'h2222);
      do_xfer(8'h30, 1'b1, 0, 16'h0);
      load(8'h31, 16'h3333);
      do_xfer(8'h31, 1'b1, 2, 16'h4444);
   endtask

   task automatic test_random();
      logic [7:0]  a;
      logic [15:0] d;
      logic        r;
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom); d = 16'($urandom);
         load(a, d);
         load(8'($urandom), 16'($urandom));
         if (model_mem[a] === 16'hxxxx) load(a, d);
         r = ($urandom_range(0, 3) != 0);
         do_xfer(a, r, $urandom_range(0, 2), 16'($urandom));
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         bus_as = 1'b1; addr = 8'($urandom);
         tick();
         bus_as = 1'b0;
         tick();
         model_err2 = sat_inc(model_err2);
         model_err0 = sat_inc(model_err0);
      end
      total_cnt++; if (err2 !== 8'(model_err2) || err0 !== 8'(model_err0)) $display("FAIL err_saturate: got %0d/%0d expected %0d/%0d", err2, err0, model_err2, model_err0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_ack();
      bus_as = 1'b1; addr = 8'h12; rw = 1'b1;
      tick(); ds = 1'b1;
      tick(); tick(); tick();
      total_cnt++; if (da2 !== 1'b1 || data2 !== 16'hBEEF) $display("FAIL rst_pre_ack: got da=%b data=%h expected 1 beef", da2, data2); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (da2 !== 1'b0 || data2 !== 16'h0 || busy2 !== 1'b0 || err2 !== 8'd0) $display("FAIL rst_mid_ack: got da=%b data=%h busy=%b err=%0d expected zeros", da2, data2, busy2, err2); else pass_cnt++;
      ds = 1'b0; bus_as = 1'b0;
      tick();
      rst = 1'b0;
      model_err2 = 0; model_err0 = 0;
      tick();
      do_xfer(8'h12, 1'b1, 0, 16'h0);
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_back_to_back();
      test_abort_wait();
      test_write_request();
      test_load_collision();
      test_random();
      test_saturation();
      test_reset_mid_ack();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
